// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side signal bundle for the hazard controller.
//   Hazard inputs : id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt,
//                   if_id_uses_rt, branch_taken, mem_busy
//   Controls      : pc_write, if_id/id_ex/ex_mem enable+flush, mem_wb_flush
//   master modport: datapath side (drives hazard inputs, consumes controls)
//   slave modport : hazard_ctrl side
interface hazard_ctrl_if;
    logic       id_ex_mem_read;
    logic [4:0] id_ex_rt;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       if_id_uses_rt;
    logic       branch_taken;
    logic       mem_busy;

    logic       pc_write;
    logic       if_id_enable;
    logic       if_id_flush;
    logic       id_ex_enable;
    logic       id_ex_flush;
    logic       ex_mem_enable;
    logic       ex_mem_flush;
    logic       mem_wb_flush;

    modport master (
        output id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
               branch_taken, mem_busy,
        input  pc_write, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
               ex_mem_enable, ex_mem_flush, mem_wb_flush
    );

    modport slave (
        input  id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
               branch_taken, mem_busy,
        output pc_write, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
               ex_mem_enable, ex_mem_flush, mem_wb_flush
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/enable decode for the 5-stage MIPS pipeline.
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   bus (slave) : hazard inputs in, PC / pipeline-register controls out
//   state       : action applied in the previous cycle (RUN/STALL/WAIT/FLUSH)
//   stall_count : saturating count of cycles with pc_write=0 (STALL or WAIT)
//   flush_count : saturating count of branch flush cycles
//   mem_timeout : sticky, set once mem_busy is held MAX_WAIT consecutive cycles
module hazard_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    hazard_ctrl_if.slave     bus,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } action_t;

    action_t           action;
    action_t           state_q;
    logic              load_use;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;

    always_comb begin
        load_use = bus.id_ex_mem_read && (bus.id_ex_rt != '0) &&
                   ((bus.id_ex_rt == bus.if_id_rs) ||
                    (bus.if_id_uses_rt && (bus.id_ex_rt == bus.if_id_rt)));
    end

    // Action select and control decode; priority WAIT > FLUSH > STALL > RUN.
    always_comb begin
        action            = RUN;
        bus.pc_write      = 1'b1;
        bus.if_id_enable  = 1'b1;
        bus.if_id_flush   = 1'b0;
        bus.id_ex_enable  = 1'b1;
        bus.id_ex_flush   = 1'b0;
        bus.ex_mem_enable = 1'b1;
        bus.ex_mem_flush  = 1'b0;
        bus.mem_wb_flush  = 1'b0;

        if (bus.mem_busy)
            action = WAIT;
        else if (bus.branch_taken)
            action = FLUSH;
        else if (load_use)
            action = STALL;

        case (action)
            WAIT: begin
                // EX/MEM is frozen too, so a taken branch waits for memory.
                bus.pc_write      = 1'b0;
                bus.if_id_enable  = 1'b0;
                bus.id_ex_enable  = 1'b0;
                bus.ex_mem_enable = 1'b0;
                bus.mem_wb_flush  = 1'b1;
            end
            FLUSH: begin
                bus.if_id_flush  = 1'b1;
                bus.id_ex_flush  = 1'b1;
                bus.ex_mem_flush = 1'b1;
            end
            STALL: begin
                bus.pc_write     = 1'b0;
                bus.if_id_enable = 1'b0;
                bus.id_ex_flush  = 1'b1;
            end
            default: ;
        endcase

        // Reset holds the whole pipeline frozen and flushed.
        if (reset) begin
            bus.pc_write      = 1'b0;
            bus.if_id_enable  = 1'b0;
            bus.if_id_flush   = 1'b1;
            bus.id_ex_enable  = 1'b0;
            bus.id_ex_flush   = 1'b1;
            bus.ex_mem_enable = 1'b0;
            bus.ex_mem_flush  = 1'b1;
            bus.mem_wb_flush  = 1'b1;
        end
    end

    always_comb begin
        wait_nxt = '0;
        if (bus.mem_busy)
            wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= RUN;
        else
            state_q <= action;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            if (bus.mem_busy && (wait_nxt == WAIT_MAX))
                mem_timeout <= 1'b1;
            if (((action == STALL) || (action == WAIT)) && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            if ((action == FLUSH) && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

    assign state = state_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. Each cycle it decides the stall, flush and enable controls for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three kinds of event:

- load-use data hazards;
- taken branches resolved in MEM;
- multi-cycle data-memory accesses.

It also keeps saturating stall/flush statistics and a sticky memory-timeout flag.

## Interface
Parameters:
- CNT_W, 16, width of the stall_count and flush_count statistic counters
- MAX_WAIT, 15, number of consecutive mem_busy cycles that sets mem_timeout

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_rt  in  5  destination rt of the instruction in EX
- if_id_rs  in  5  instruction[25:21] in ID
- if_id_rt  in  5  instruction[20:16] in ID
- if_id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq, sw)
- branch_taken  in  1  branch in MEM is taken (branch & zero)
- mem_busy  in  1  data memory has not completed the access in MEM
- pc_write  out  1  PC load enable
- if_id_enable, if_id_flush  out  1 each
- id_ex_enable, id_ex_flush  out  1 each
- ex_mem_enable, ex_mem_flush  out  1 each
- mem_wb_flush  out  1  inserts a bubble into WB
- state  out  2  registered action of the previous cycle: RUN=0, STALL=1, WAIT=2, FLUSH=3
- stall_count  out  CNT_W  cycles with pc_write=0, excluding reset
- flush_count  out  CNT_W  branch flush events
- mem_timeout  out  1  sticky: mem_busy was held for MAX_WAIT consecutive cycles

## Operation
The control outputs are decoded combinationally from the inputs each cycle. Exactly one action applies per cycle, chosen by the first matching priority below.

1. **WAIT** (mem_busy=1)
   - pc_write=0, all enables=0, mem_wb_flush=1, other flushes=0.
   - branch_taken is ignored. EX/MEM is frozen, so a taken branch stays asserted until the memory completes.
2. **FLUSH** (branch_taken=1)
   - pc_write=1, all enables=1.
   - if_id_flush=id_ex_flush=ex_mem_flush=1, mem_wb_flush=0.
   - Overrides any simultaneous load-use hazard.
3. **STALL** (load-use hazard)
   - Hazard condition: id_ex_mem_read & (id_ex_rt≠0) & ((id_ex_rt==if_id_rs) | (if_id_uses_rt & id_ex_rt==if_id_rt)).
   - pc_write=0, if_id_enable=0, id_ex_enable=1, id_ex_flush=1, ex_mem_enable=1, other flushes=0.
4. **RUN** (no event)
   - pc_write=1, all enables=1, all flushes=0.

Sequential state:
- state register: loaded each cycle with the action code applied that cycle.
- stall_count: +1 on every STALL or WAIT cycle; saturates at 2^CNT_W−1.
- flush_count: +1 on every FLUSH cycle; saturates at 2^CNT_W−1.
- wait counter (internal, width ≥ clog2(MAX_WAIT+1)):
  - increments while mem_busy=1 and clears when mem_busy=0;
  - saturates at MAX_WAIT;
  - on the edge where it reaches MAX_WAIT, mem_timeout is set to 1.
- mem_timeout: once set, cleared only by reset.

While reset=1:
- control outputs are forced to pc_write=0, all enables=0, all flushes=1;
- state=RUN(0), stall_count=0, flush_count=0, wait counter=0, mem_timeout=0.

## Timing
- Decode latency is zero: controls are valid in the same cycle as the inputs, and the pipeline registers act on them at the next rising edge.
- Load-use stall lasts exactly 1 cycle. On the following edge the load has moved to MEM, so the hazard term clears naturally.
- A WAIT of N busy cycles freezes the pipeline for N cycles and produces N MEM/WB bubbles. Normal action resumes in the first cycle with mem_busy=0.
- The state, counter and timeout outputs update on the rising edge after the cycle that caused them.
- Reset assertion takes effect immediately (asynchronous), including mid-WAIT or mid-stall. Deassertion is followed by RUN behaviour in the next cycle unless an event input is asserted.
- Counter saturation: at all-ones, a further event leaves the value unchanged (no wrap).

## Test plan
- **Load-use stall:** id_ex_mem_read=1, id_ex_rt=8, if_id_rs=8 for 1 cycle.
  - Required: pc_write=0, if_id_enable=0, id_ex_flush=1; next edge state=1, stall_count=1.
  - Repeat with id_ex_rt=0: no stall.
  - Repeat with if_id_rt=8, if_id_uses_rt=0: no stall.
- **Branch overrides stall:** branch_taken=1 together with a load-use hazard.
  - Required: FLUSH action (three flushes=1, pc_write=1); flush_count=1, stall_count unchanged.
- **Memory wait:** mem_busy=1 for 3 cycles with branch_taken=1.
  - Required: each cycle all enables=0, mem_wb_flush=1, no flush of IF/ID, ID/EX or EX/MEM.
  - Then FLUSH on the 4th cycle; stall_count=3, flush_count=1.
- **Timeout:** mem_busy=1 for 15 cycles.
  - Required: mem_timeout=1 after the 15th edge, and it stays 1 after mem_busy drops.
  - With 14 cycles instead: mem_timeout stays 0.
- **Saturation:** CNT_W=4, apply 20 load-use stalls.
  - Required: stall_count=15 and holds there.
- **Async reset mid-WAIT:** assert reset between clock edges during mem_busy=1.
  - Required: outputs immediately forced to reset values; counters and mem_timeout=0 without waiting for a clock edge.
